// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: Y86-64 opcode/register constants and fetch FSM state type
package ifetch_unit_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] FNONE   = 4'h0;
    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_BYTE0, S_REGS, S_CONST, S_DONE} state_t;

    // Next sequential PC: opcode byte, optional register byte, optional 8-byte constant
    function automatic logic [63:0] calc_valp(input logic [63:0] pc, input logic regids, input logic valc);
        return pc + 64'd1 + {63'd0, regids} + {60'd0, valc, 3'd0};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: byte-wide instruction memory port
interface ifetch_unit_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack, imem_err);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack, imem_err);

endinterface

// File: rtl/ifetch_unit_icode_class.sv
// icode_class: classifies an icode into register-byte / constant-word needs and validity
module icode_class
    import ifetch_unit_pkg::*;
(
    input  logic [3:0] icode,
    output logic       need_regids,
    output logic       need_valc,
    output logic       instr_valid
);

    assign need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    assign need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    assign instr_valid = icode inside {IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                                       IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ};

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: multi-cycle Y86-64 fetch, one instruction byte per memory transfer
module ifetch_unit
    import ifetch_unit_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [63:0]   pc_i,
    output logic          ready_o,
    ifetch_unit_if.master bus,
    output logic          done_o,
    output logic [3:0]    icode_o,
    output logic [3:0]    ifun_o,
    output logic [3:0]    rA_o,
    output logic [3:0]    rB_o,
    output logic [63:0]   valC_o,
    output logic [63:0]   valP_o,
    output logic          instr_valid_o,
    output logic          imem_error_o
);

    state_t      state, state_nx;
    logic [63:0] addr;
    logic [2:0]  cnt;
    logic        need_valc;
    logic        busy, ack, err;
    logic        cls_regids, cls_valc, cls_valid;

    // Request and status are pure decodes of the state register, so no memory input reaches an output
    assign busy          = state inside {S_BYTE0, S_REGS, S_CONST};
    assign ack           = busy & bus.imem_ack;
    assign err           = ack & bus.imem_err;
    assign bus.imem_req  = busy;
    assign bus.imem_addr = addr;
    assign ready_o       = state == S_IDLE;
    assign done_o        = state == S_DONE;

    icode_class u_class (
        .icode       (bus.imem_rdata[7:4]),
        .need_regids (cls_regids),
        .need_valc   (cls_valc),
        .instr_valid (cls_valid)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state: each fetch phase advances on ack; an errored ack jumps straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start_i ? S_BYTE0 : S_IDLE;
            S_BYTE0: if (ack) state_nx = err ? S_DONE : cls_regids ? S_REGS : cls_valc ? S_CONST : S_DONE;
            S_REGS:  if (ack) state_nx = (!err && need_valc) ? S_CONST : S_DONE;
            S_CONST: if (ack) state_nx = (err || cnt == 3'd7) ? S_DONE : S_CONST;
            default: state_nx = S_IDLE;
        endcase
    end

    // Address, byte counter and result assembly
    always_ff @(posedge clk_i) begin
        if (rst_i || (state == S_IDLE && start_i)) begin
            addr          <= rst_i ? 64'd0 : pc_i;
            cnt           <= 3'd0;
            need_valc     <= 1'b0;
            icode_o       <= 4'h0;
            ifun_o        <= 4'h0;
            rA_o          <= RNONE;
            rB_o          <= RNONE;
            valC_o        <= 64'd0;
            valP_o        <= 64'd0;
            instr_valid_o <= 1'b0;
            imem_error_o  <= 1'b0;
        end else if (ack) begin
            addr <= addr + 64'd1;
            if (err) begin
                imem_error_o  <= 1'b1;
                icode_o       <= INOP;
                ifun_o        <= FNONE;
                instr_valid_o <= 1'b1;
            end else begin
                case (state)
                    S_BYTE0: begin
                        icode_o       <= bus.imem_rdata[7:4];
                        ifun_o        <= bus.imem_rdata[3:0];
                        need_valc     <= cls_valc;
                        instr_valid_o <= cls_valid;
                        valP_o        <= calc_valp(addr, cls_regids, cls_valc);
                    end
                    S_REGS: begin
                        rA_o <= bus.imem_rdata[7:4];
                        rB_o <= bus.imem_rdata[3:0];
                    end
                    S_CONST: begin
                        valC_o[{cnt, 3'b000} +: 8] <= bus.imem_rdata;
                        cnt                        <= cnt + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven check of ifetch_unit against a byte-wide memory model
module tb_ifetch_unit;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        int          waits;
        int          err_at;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, merr;
        int          lat, nacks;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [63:0] pc_i;
    logic        ready_o, done_o, instr_valid_o, imem_error_o;
    logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
    logic [63:0] valC_o, valP_o;

    vec_t        v[8];
    vec_t        cur;
    int          acks, wcnt, ko, dones;
    int          total = 0;
    int          bad = 0;
    logic [63:0] off;

    ifetch_unit_if bus ();

    ifetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .ready_o       (ready_o),
        .bus           (bus.master),
        .done_o        (done_o),
        .icode_o       (icode_o),
        .ifun_o        (ifun_o),
        .rA_o          (rA_o),
        .rB_o          (rB_o),
        .valC_o        (valC_o),
        .valP_o        (valP_o),
        .instr_valid_o (instr_valid_o),
        .imem_error_o  (imem_error_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [63:0] pc, input logic [79:0] bytes, input int waits, input int err_at,
                                input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] valc, input logic [63:0] valp, input logic valid, input logic merr,
                                input int lat, input int nacks);
        vec_t t;
        t.pc = pc; t.bytes = bytes; t.waits = waits; t.err_at = err_at;
        t.icode = icode; t.ifun = ifun; t.ra = ra; t.rb = rb;
        t.valc = valc; t.valp = valp; t.valid = valid; t.merr = merr;
        t.lat = lat; t.nacks = nacks;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: byte stream of the current vector, 'waits' idle cycles before each ack,
    // error on the err_at-th ack; garbage ack/err while req is low or waiting must be ignored
    initial begin
        bus.imem_ack = 1'b0; bus.imem_err = 1'b0; bus.imem_rdata = 8'h00;
        wcnt = 0; acks = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_req) begin
                if (wcnt == cur.waits) begin
                    off = bus.imem_addr - cur.pc;
                    acks++;
                    bus.imem_ack = 1'b1;
                    bus.imem_err = (acks == cur.err_at);
                    bus.imem_rdata = 8'h00;
                    if (off < 64'd10) begin
                        ko = int'(off);
                        bus.imem_rdata = cur.bytes[79-8*ko -: 8];
                    end
                    wcnt = 0;
                end else begin
                    bus.imem_ack = 1'b0; bus.imem_err = 1'b1; bus.imem_rdata = 8'h5A;
                    wcnt++;
                end
            end else begin
                bus.imem_ack = 1'b1; bus.imem_err = 1'b1; bus.imem_rdata = 8'hEE;
                wcnt = 0;
            end
        end
    end

    task automatic run(input vec_t t, input bit hold, input string name);
        int cyc;
        cur = t;
        acks = 0;
        @(negedge clk);
        start_i = 1'b1;
        pc_i = t.pc;
        @(posedge clk); #1;
        cyc = 1;
        chk({name, ".ready_busy"}, ready_o, 0);
        while (!done_o && cyc < 400) begin
            @(negedge clk);
            start_i = hold && cyc < 3;
            pc_i = 64'h999;
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        chk({name, ".latency"}, cyc, t.lat);
        chk({name, ".icode"}, icode_o, t.icode);
        chk({name, ".ifun"}, ifun_o, t.ifun);
        chk({name, ".rA"}, rA_o, t.ra);
        chk({name, ".rB"}, rB_o, t.rb);
        chk({name, ".valC"}, valC_o, t.valc);
        if (!t.merr) chk({name, ".valP"}, valP_o, t.valp);
        chk({name, ".valid"}, instr_valid_o, t.valid);
        chk({name, ".merr"}, imem_error_o, t.merr);
        chk({name, ".req_done"}, bus.imem_req, 0);
        chk({name, ".acks"}, acks, t.nacks);
        @(posedge clk); #1;
        chk({name, ".done_pulse"}, done_o, 0);
        chk({name, ".ready_after"}, ready_o, 1);
        chk({name, ".hold_icode"}, icode_o, t.icode);
        chk({name, ".hold_valC"}, valC_o, t.valc);
        chk({name, ".acks_after"}, acks, t.nacks);
    endtask

    initial begin
        v[0] = mk(64'h40, {8'h10, 72'h0}, 0, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1, 0, 2, 1);
        v[1] = mk(64'h100, {8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}, 0, 0,
                  4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10A, 1, 0, 11, 10);
        v[2] = mk(64'h200, {8'h74, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0,
                  4'h7, 4'h4, 4'hF, 4'hF, 64'h300, 64'h209, 1, 0, 28, 9);
        v[3] = mk(64'h10, {8'hC0, 72'h0}, 0, 0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h11, 0, 0, 2, 1);
        v[4] = mk(64'h300, {8'h50, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 0, 5,
                  4'h1, 4'h0, 4'h1, 4'h2, 64'h2211, 64'h30A, 1, 1, 6, 5);
        v[5] = mk(64'hFFFF_FFFF_FFFF_FFFF, {8'h20, 8'h45, 64'h0}, 0, 0,
                  4'h2, 4'h0, 4'h4, 4'h5, 64'h0, 64'h1, 1, 0, 3, 2);
        v[6] = mk(64'h80, {8'h90, 72'h0}, 1, 0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h81, 1, 0, 3, 1);
        v[7] = mk(64'h1000, {8'h80, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0,
                  4'h8, 4'h0, 4'hF, 4'hF, 64'h2000, 64'h1009, 1, 0, 10, 9);
        cur = v[0];
        rst_i = 1'b1; start_i = 1'b0; pc_i = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", ready_o, 1);
        chk("reset.req", bus.imem_req, 0);
        chk("reset.done", done_o, 0);
        chk("reset.rA", rA_o, 4'hF);
        chk("reset.rB", rB_o, 4'hF);
        chk("reset.icode", icode_o, 0);
        chk("reset.valP", valP_o, 0);
        chk("reset.valid", instr_valid_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) run(v[i], 1'b0, $sformatf("vec%0d", i));

        run(v[1], 1'b1, "start_in_regs");

        cur = v[1];
        acks = 0;
        @(negedge clk);
        start_i = 1'b1;
        pc_i = v[1].pc;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("rst_mid.req", bus.imem_req, 0);
        chk("rst_mid.done", done_o, 0);
        chk("rst_mid.ready", ready_o, 1);
        chk("rst_mid.rA", rA_o, 4'hF);
        chk("rst_mid.icode", icode_o, 0);
        chk("rst_mid.valC", valC_o, 0);
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_o || bus.imem_req) dones++;
        end
        chk("rst_mid.quiet", dones, 0);
        run(v[0], 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
